// File: rtl/fads_sort_pulse.sv
// rtl/fads_sort_pulse.sv - timed sort pulse generator with hold-off and event counters
// Converts each rising sort decision into a delayed fixed-width ASG trigger pulse.
module fads_sort_pulse #(
    parameter int CW   = 32,
    parameter int CMIN = 1
) (
    input  logic        adc_clk_i,
    input  logic        adc_rstn_i,
    input  logic        sort_trig_i,
    output logic        sort_pulse_o,
    output logic        busy_o,
    input  logic [31:0] sys_addr,
    input  logic [31:0] sys_wdata,
    input  logic [3:0]  sys_sel,
    input  logic        sys_wen,
    input  logic        sys_ren,
    output logic [31:0] sys_rdata,
    output logic        sys_err,
    output logic        sys_ack
);

    localparam logic [19:0] ADDR_DELAY   = 20'h00000;
    localparam logic [19:0] ADDR_WIDTH   = 20'h00004;
    localparam logic [19:0] ADDR_HOLDOFF = 20'h00008;
    localparam logic [19:0] ADDR_CTRL    = 20'h0000C;
    localparam logic [19:0] ADDR_FIRED   = 20'h00010;
    localparam logic [19:0] ADDR_DROPPED = 20'h00014;
    localparam logic [19:0] ADDR_STATUS  = 20'h00018;

    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] CMIN_W  = CW'(CMIN);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pulse_q;
    logic          trig_d;

    logic [CW-1:0] delay_q;
    logic [CW-1:0] width_q;
    logic [CW-1:0] holdoff_q;
    logic          en_q;
    logic [CW-1:0] fired_q;
    logic [CW-1:0] dropped_q;

    logic          ack_q;
    logic [31:0]   rdata_q;
    logic [31:0]   rd_val;

    logic [19:0]   addr;
    logic          trig_event;
    logic          fire;
    logic          drop;
    logic          clr_cnt;
    logic [CW-1:0] width_eff;
    logic          unused_ok;

    assign addr       = sys_addr[19:0];
    assign trig_event = sort_trig_i & ~trig_d;
    assign clr_cnt    = sys_wen && (addr == ADDR_CTRL) && sys_wdata[1];
    assign width_eff  = (width_q < CMIN_W) ? CMIN_W : width_q;
    assign unused_ok  = ^{sys_sel, sys_addr[31:20]};

    assign sort_pulse_o = pulse_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign sys_ack      = ack_q;
    assign sys_rdata    = rdata_q;
    assign sys_err      = 1'b0;

    // Next-state logic; an event outside IDLE is always rejected and counted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        drop    = trig_event && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (trig_event && en_q) begin
                    fire = 1'b1;
                    if (delay_q == '0) begin
                        state_d = ST_PULSE;
                        cnt_d   = width_eff;
                    end else begin
                        state_d = ST_DELAY;
                        cnt_d   = delay_q;
                    end
                end
            end
            ST_DELAY: begin
                cnt_d = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    state_d = ST_PULSE;
                    cnt_d   = width_eff;
                end
            end
            ST_PULSE: begin
                cnt_d = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    if (holdoff_q == '0) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = holdoff_q;
                    end
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Disabling aborts any operation in progress without touching the counters.
        if (!en_q && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            trig_d  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= (state_d == ST_PULSE);
            trig_d  <= sort_trig_i;
        end
    end

    // Clear-counters takes priority over a coincident fire or drop.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            fired_q   <= '0;
            dropped_q <= '0;
        end else if (clr_cnt) begin
            fired_q   <= '0;
            dropped_q <= '0;
        end else begin
            if (fire && (fired_q != CNT_MAX)) begin
                fired_q <= fired_q + ONE;
            end
            if (drop && (dropped_q != CNT_MAX)) begin
                dropped_q <= dropped_q + ONE;
            end
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            delay_q   <= '0;
            width_q   <= CMIN_W;
            holdoff_q <= '0;
            en_q      <= 1'b0;
        end else if (sys_wen) begin
            case (addr)
                ADDR_DELAY:   delay_q   <= CW'(sys_wdata);
                ADDR_WIDTH:   width_q   <= CW'(sys_wdata);
                ADDR_HOLDOFF: holdoff_q <= CW'(sys_wdata);
                ADDR_CTRL:    en_q      <= sys_wdata[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_val = 32'd0;
        case (addr)
            ADDR_DELAY:   rd_val = 32'(delay_q);
            ADDR_WIDTH:   rd_val = 32'(width_q);
            ADDR_HOLDOFF: rd_val = 32'(holdoff_q);
            ADDR_CTRL:    rd_val = {31'd0, en_q};
            ADDR_FIRED:   rd_val = 32'(fired_q);
            ADDR_DROPPED: rd_val = 32'(dropped_q);
            ADDR_STATUS:  rd_val = {29'd0, pulse_q, state_q};
            default:      rd_val = 32'd0;
        endcase
    end

    // Read data is captured at the request edge, so counters show their pre-update value.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ack_q <= sys_wen | sys_ren;
            if (sys_ren) begin
                rdata_q <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_fads_sort_pulse.sv
// tb/tb_fads_sort_pulse.sv - directed self-checking bench for fads_sort_pulse
module tb_fads_sort_pulse;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trig = 1'b0;
    logic        pulse;
    logic        busy;
    logic [31:0] sys_addr = 32'd0;
    logic [31:0] sys_wdata = 32'd0;
    logic [3:0]  sys_sel = 4'hF;
    logic        sys_wen = 1'b0;
    logic        sys_ren = 1'b0;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    int total = 0;
    int bad = 0;

    localparam logic [31:0] A_DELAY   = 32'h00;
    localparam logic [31:0] A_WIDTH   = 32'h04;
    localparam logic [31:0] A_HOLDOFF = 32'h08;
    localparam logic [31:0] A_CTRL    = 32'h0C;
    localparam logic [31:0] A_FIRED   = 32'h10;
    localparam logic [31:0] A_DROPPED = 32'h14;
    localparam logic [31:0] A_STATUS  = 32'h18;

    fads_sort_pulse dut (
        .adc_clk_i   (clk),
        .adc_rstn_i  (rst_n),
        .sort_trig_i (trig),
        .sort_pulse_o(pulse),
        .busy_o      (busy),
        .sys_addr    (sys_addr),
        .sys_wdata   (sys_wdata),
        .sys_sel     (sys_sel),
        .sys_wen     (sys_wen),
        .sys_ren     (sys_ren),
        .sys_rdata   (sys_rdata),
        .sys_err     (sys_err),
        .sys_ack     (sys_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [31:0] w;
        logic [31:0] h;
        int          first;
        int          last;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        sys_addr  = a;
        sys_wdata = d;
        sys_wen   = 1'b1;
        @(negedge clk);
        check("wr ack", {31'd0, sys_ack}, 32'd1);
        sys_wen = 1'b0;
        @(negedge clk);
        check("wr ack one cycle", {31'd0, sys_ack}, 32'd0);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        sys_addr = a;
        sys_ren  = 1'b1;
        @(negedge clk);
        check("rd ack", {31'd0, sys_ack}, 32'd1);
        d       = sys_rdata;
        sys_ren = 1'b0;
        @(negedge clk);
        check("rd ack one cycle", {31'd0, sys_ack}, 32'd0);
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        check(name, v, exp);
    endtask

    task automatic cfg(input logic [31:0] d, input logic [31:0] w, input logic [31:0] h);
        bus_write(A_DELAY, d);
        bus_write(A_WIDTH, w);
        bus_write(A_HOLDOFF, h);
        bus_write(A_CTRL, 32'd3);
    endtask

    // First event at edge N; optional later events at edges N+e2 and N+e3 (-1 = none).
    task automatic run_events(input string tag, input int e2, input int e3, input int len,
                              input int p1s, input int p1e, input int p2s, input int p2e);
        logic exp;
        trig = 1'b1;
        for (int k = 0; k <= len; k++) begin
            @(negedge clk);
            exp = ((k >= p1s) && (k < p1e)) || ((k >= p2s) && (k < p2e));
            check($sformatf("%s pulse k=%0d", tag, k), {31'd0, pulse}, {31'd0, exp});
            trig = ((k + 1) == e2) || ((k + 1) == e3);
        end
        check({tag, " idle at end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        int          highs;

        vt[0] = '{32'd10, 32'd5, 32'd0, 10, 15};
        vt[1] = '{32'd0,  32'd0, 32'd0, 0,  1};
        vt[2] = '{32'd0,  32'd1, 32'd0, 0,  1};
        vt[3] = '{32'd1,  32'd1, 32'd0, 1,  2};
        vt[4] = '{32'd3,  32'd4, 32'd0, 3,  7};
        vt[5] = '{32'd0,  32'd3, 32'd2, 0,  3};
        vt[6] = '{32'd2,  32'd0, 32'd5, 2,  3};

        repeat (3) @(negedge clk);
        check("rst pulse", {31'd0, pulse}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst ack", {31'd0, sys_ack}, 32'd0);
        check("rst err", {31'd0, sys_err}, 32'd0);
        check("rst rdata", sys_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        read_check("rst DELAY", A_DELAY, 32'd0);
        read_check("rst WIDTH", A_WIDTH, 32'd1);
        read_check("rst HOLDOFF", A_HOLDOFF, 32'd0);
        read_check("rst CTRL", A_CTRL, 32'd0);
        read_check("rst FIRED", A_FIRED, 32'd0);
        read_check("rst DROPPED", A_DROPPED, 32'd0);
        read_check("rst STATUS", A_STATUS, 32'd0);

        bus_write(A_WIDTH, 32'd7);
        read_check("WIDTH rb", A_WIDTH, 32'd7);
        read_check("WIDTH alias above bit19", 32'h0010_0004, 32'd7);
        read_check("unmapped 0x20", 32'h20, 32'd0);
        bus_write(A_FIRED, 32'd55);
        read_check("FIRED ro", A_FIRED, 32'd0);
        bus_write(A_CTRL, 32'd3);
        read_check("CTRL bit1 self-clears", A_CTRL, 32'd1);

        for (int i = 0; i < 7; i++) begin
            cfg(vt[i].d, vt[i].w, vt[i].h);
            run_events($sformatf("vec%0d", i), -1, -1, vt[i].last + int'(vt[i].h) + 3,
                       vt[i].first, vt[i].last, -1, -1);
            read_check($sformatf("vec%0d FIRED", i), A_FIRED, 32'd1);
            read_check($sformatf("vec%0d DROPPED", i), A_DROPPED, 32'd0);
            read_check($sformatf("vec%0d STATUS", i), A_STATUS, 32'd0);
        end

        bus_write(A_CTRL, 32'd2);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        check("disabled busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        read_check("disabled FIRED", A_FIRED, 32'd0);
        read_check("disabled DROPPED", A_DROPPED, 32'd0);

        cfg(32'd2, 32'd3, 32'd20);
        run_events("holdoff", 10, 26, 55, 2, 5, 28, 31);
        read_check("holdoff FIRED", A_FIRED, 32'd2);
        read_check("holdoff DROPPED", A_DROPPED, 32'd1);

        cfg(32'd2, 32'd3, 32'd20);
        run_events("holdoff edge", 25, -1, 30, 2, 5, -1, -1);
        read_check("holdoff edge FIRED", A_FIRED, 32'd1);
        read_check("holdoff edge DROPPED", A_DROPPED, 32'd1);

        cfg(32'd2, 32'd3, 32'd0);
        trig  = 1'b1;
        highs = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (pulse) highs++;
        end
        trig = 1'b0;
        @(negedge clk);
        check("level pulse cycles", 32'(highs), 32'd3);
        read_check("level FIRED", A_FIRED, 32'd1);
        read_check("level DROPPED", A_DROPPED, 32'd0);

        cfg(32'd0, 32'd1, 32'd0);
        trig = 1'b1;
        bus_write(A_CTRL, 32'd3);
        trig = 1'b0;
        read_check("clear beats event", A_FIRED, 32'd0);
        trig = 1'b1;
        bus_read(A_FIRED, v);
        trig = 1'b0;
        check("read sees pre-update", v, 32'd0);
        read_check("read after event", A_FIRED, 32'd1);

        cfg(32'd0, 32'd10, 32'd0);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        check("abort pulse on", {31'd0, pulse}, 32'd1);
        repeat (2) @(negedge clk);
        bus_write(A_CTRL, 32'd0);
        check("abort pulse off", {31'd0, pulse}, 32'd0);
        check("abort busy off", {31'd0, busy}, 32'd0);
        read_check("abort FIRED", A_FIRED, 32'd1);

        cfg(32'd50, 32'd5, 32'd0);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        repeat (5) @(negedge clk);
        check("mid-delay busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", {31'd0, busy}, 32'd0);
        check("async rst pulse", {31'd0, pulse}, 32'd0);
        check("async rst rdata", sys_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_check("post-rst DELAY", A_DELAY, 32'd0);
        read_check("post-rst WIDTH", A_WIDTH, 32'd1);
        read_check("post-rst CTRL", A_CTRL, 32'd0);
        read_check("post-rst FIRED", A_FIRED, 32'd0);

        cfg(32'd0, 32'd20, 32'd0);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        repeat (2) @(negedge clk);
        check("mid-pulse on", {31'd0, pulse}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst mid-pulse", {31'd0, pulse}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
